// File: rtl/ascensor_pkg.sv
// ascensor_pkg
//   Definitions shared by the elevator-car blocks: the door controller,
//   the door-open timeout timer and the cabin controller.
//   - EST_* : 2-bit door-state encodings exported on control_puertas.estado
//   - estado_puerta_t : internal door FSM state
//   - codifica_estado : maps an internal state to its exported encoding
package ascensor_pkg;

    localparam logic [1:0] EST_CERRADA  = 2'b00;
    localparam logic [1:0] EST_ABIERTA  = 2'b01;
    localparam logic [1:0] EST_CERRANDO = 2'b10;
    localparam logic [1:0] EST_ABRIENDO = 2'b11;

    typedef enum logic [2:0] {
        ST_CERRADA,
        ST_ABRIENDO,
        ST_ABIERTA,
        ST_CERRANDO,
        ST_FALLA
    } estado_puerta_t;

    // FALLA has no code of its own; it shares 11 with ABRIENDO and is told
    // apart by the falla flag.
    function automatic logic [1:0] codifica_estado(input estado_puerta_t s);
        logic [1:0] e;
        e = EST_ABRIENDO;
        case (s)
            ST_CERRADA:  e = EST_CERRADA;
            ST_ABIERTA:  e = EST_ABIERTA;
            ST_CERRANDO: e = EST_CERRANDO;
            default:     e = EST_ABRIENDO;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/control_puertas_vigia_mov.sv
// vigia_mov
//   Saturating movement watchdog for the door controller.
//   Ports:
//     clk    in   system clock
//     rst    in   synchronous active-high reset
//     clr    in   clear count to zero (has priority over en)
//     en     in   count one per cycle while high
//     expira out  high while the count equals MOV_MAX
//   The count saturates at MOV_MAX and never wraps.
module vigia_mov #(
    parameter int unsigned MOV_MAX = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expira
);

    localparam logic [CNT_W-1:0] LIMITE = CNT_W'(MOV_MAX);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LIMITE)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expira = (cnt_q == LIMITE);

endmodule

// File: rtl/control_puertas.sv
// control_puertas
//   Door controller FSM for the elevator car.
//   Ports:
//     clk            in   system clock
//     rst            in   synchronous active-high reset
//     abrir          in   open request (level)
//     obstaculo      in   light curtain, 1 = blocked
//     fin_abierta    in   limit switch, 1 = fully open
//     fin_cerrada    in   limit switch, 1 = fully closed
//     timeout        in   door-open timer expired
//     cerrar         in   cabin close button (only with BOTON_CERRAR_EN)
//     estado         out  00 CERRADA, 01 ABIERTA, 10 CERRANDO, 11 ABRIENDO/FALLA
//     motor_abrir    out  open-motor drive
//     motor_cerrar   out  close-motor drive
//     puerta_cerrada out  1 only in CERRADA
//     falla          out  latched fault
//   Build option: define BOTON_CERRAR_EN to let cerrar close the door early
//   from ABIERTA; otherwise cerrar is ignored.
//   All outputs are registered Moore outputs decoded from the next state.
module control_puertas
    import ascensor_pkg::*;
#(
    parameter int unsigned MOV_MAX = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       abrir,
    input  logic       obstaculo,
    input  logic       fin_abierta,
    input  logic       fin_cerrada,
    input  logic       timeout,
    input  logic       cerrar,
    output logic [1:0] estado,
    output logic       motor_abrir,
    output logic       motor_cerrar,
    output logic       puerta_cerrada,
    output logic       falla
);

    estado_puerta_t state_q, state_d;
    logic [1:0]     estado_q;
    logic           motor_abrir_q, motor_cerrar_q, puerta_cerrada_q, falla_q;
    logic           vigia_clr, vigia_en, vigia_expira;
    logic           pedir_cierre;

`ifdef BOTON_CERRAR_EN
    assign pedir_cierre = timeout || cerrar;
`else
    logic unused_cerrar;
    assign unused_cerrar = cerrar;
    assign pedir_cierre  = timeout;
`endif

    // Watchdog restarts on every state change and runs only while the
    // door is moving.
    assign vigia_clr = (state_d != state_q);
    assign vigia_en  = (state_q == ST_ABRIENDO) || (state_q == ST_CERRANDO);

    vigia_mov #(
        .MOV_MAX (MOV_MAX),
        .CNT_W   (CNT_W)
    ) u_vigia (
        .clk    (clk),
        .rst    (rst),
        .clr    (vigia_clr),
        .en     (vigia_en),
        .expira (vigia_expira)
    );

    always_comb begin
        state_d = state_q;
        // Both limit switches active is physically impossible; treat as a
        // sensor fault ahead of every other transition.
        if ((state_q != ST_FALLA) && fin_abierta && fin_cerrada) begin
            state_d = ST_FALLA;
        end else begin
            case (state_q)
                ST_CERRADA: begin
                    if (abrir) state_d = ST_ABRIENDO;
                end
                ST_ABRIENDO: begin
                    if (fin_abierta)       state_d = ST_ABIERTA;
                    else if (vigia_expira) state_d = ST_FALLA;
                end
                ST_ABIERTA: begin
                    if (pedir_cierre && !obstaculo) state_d = ST_CERRANDO;
                end
                ST_CERRANDO: begin
                    // Reopen wins over a simultaneous fully-closed switch.
                    if (obstaculo || abrir) state_d = ST_ABRIENDO;
                    else if (fin_cerrada)   state_d = ST_CERRADA;
                    else if (vigia_expira)  state_d = ST_FALLA;
                end
                ST_FALLA: state_d = ST_FALLA;
                default:  state_d = ST_FALLA;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_CERRADA;
            estado_q         <= EST_CERRADA;
            motor_abrir_q    <= 1'b0;
            motor_cerrar_q   <= 1'b0;
            puerta_cerrada_q <= 1'b1;
            falla_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            estado_q         <= codifica_estado(state_d);
            motor_abrir_q    <= (state_d == ST_ABRIENDO);
            motor_cerrar_q   <= (state_d == ST_CERRANDO);
            puerta_cerrada_q <= (state_d == ST_CERRADA);
            falla_q          <= (state_d == ST_FALLA);
        end
    end

    assign estado         = estado_q;
    assign motor_abrir    = motor_abrir_q;
    assign motor_cerrar   = motor_cerrar_q;
    assign puerta_cerrada = puerta_cerrada_q;
    assign falla          = falla_q;

endmodule

// File: tb/tb_control_puertas.sv
// tb_control_puertas
//   Directed bench for control_puertas with MOV_MAX = 8. Observed outputs
//   are packed as {estado, motor_abrir, motor_cerrar, puerta_cerrada, falla}.
module tb_control_puertas;

    localparam logic [5:0] O_CERRADA  = 6'b00_0_0_1_0;
    localparam logic [5:0] O_ABRIENDO = 6'b11_1_0_0_0;
    localparam logic [5:0] O_ABIERTA  = 6'b01_0_0_0_0;
    localparam logic [5:0] O_CERRANDO = 6'b10_0_1_0_0;
    localparam logic [5:0] O_FALLA    = 6'b11_0_0_0_1;

    logic       clk = 1'b0;
    logic       rst, abrir, obstaculo, fin_abierta, fin_cerrada, timeout, cerrar;
    logic [1:0] estado;
    logic       motor_abrir, motor_cerrar, puerta_cerrada, falla;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       r, a, o, fa, fc, to, ce;
        logic [5:0] exp;
        string      nombre;
    } vec_t;

    vec_t tabla[$];

    control_puertas #(
        .MOV_MAX (8),
        .CNT_W   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .abrir          (abrir),
        .obstaculo      (obstaculo),
        .fin_abierta    (fin_abierta),
        .fin_cerrada    (fin_cerrada),
        .timeout        (timeout),
        .cerrar         (cerrar),
        .estado         (estado),
        .motor_abrir    (motor_abrir),
        .motor_cerrar   (motor_cerrar),
        .puerta_cerrada (puerta_cerrada),
        .falla          (falla)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, a, o, fa, fc, to, ce,
                       input logic [5:0] e, input string n);
        vec_t v;
        v = '{r: r, a: a, o: o, fa: fa, fc: fc, to: to, ce: ce, exp: e, nombre: n};
        tabla.push_back(v);
    endtask

    // Apply inputs, take one rising edge, settle 1 time unit.
    task automatic ciclo(input logic r, a, o, fa, fc, to, ce);
        rst = r; abrir = a; obstaculo = o; fin_abierta = fa;
        fin_cerrada = fc; timeout = to; cerrar = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic comprobar(input string n, input logic [5:0] exp);
        logic [5:0] act;
        act = {estado, motor_abrir, motor_cerrar, puerta_cerrada, falla};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    task automatic paso(input logic r, a, o, fa, fc, to, ce,
                        input logic [5:0] e, input string n);
        ciclo(r, a, o, fa, fc, to, ce);
        comprobar(n, e);
    endtask

    initial begin
        rst = 1'b1; abrir = 1'b0; obstaculo = 1'b0; fin_abierta = 1'b0;
        fin_cerrada = 1'b0; timeout = 1'b0; cerrar = 1'b0;

        //  r  a  o  fa fc to ce
        add(1, 0, 0, 0, 0, 0, 0, O_CERRADA,  "reset0");
        add(1, 0, 0, 0, 0, 0, 0, O_CERRADA,  "reset1");
        add(0, 1, 0, 0, 0, 0, 0, O_ABRIENDO, "abrir_arranca");
        add(0, 0, 0, 0, 0, 0, 0, O_ABRIENDO, "abriendo1");
        add(0, 0, 0, 0, 0, 0, 0, O_ABRIENDO, "abriendo2");
        add(0, 0, 0, 1, 0, 0, 0, O_ABIERTA,  "fin_abierta");
        add(0, 1, 0, 1, 0, 0, 0, O_ABIERTA,  "abrir_ignorado");
        add(0, 0, 0, 1, 0, 1, 0, O_CERRANDO, "timeout_cierra");
        add(0, 0, 0, 0, 0, 1, 0, O_CERRANDO, "timeout_ignorado");
        add(0, 0, 1, 0, 1, 0, 0, O_ABRIENDO, "reapertura_prioridad");
        add(0, 0, 0, 1, 0, 0, 0, O_ABIERTA,  "reabierta");
        add(0, 0, 1, 1, 0, 1, 0, O_ABIERTA,  "obstaculo_retiene");
        add(0, 0, 0, 1, 0, 1, 0, O_CERRANDO, "cierra_tras_obst");
        add(0, 0, 0, 0, 1, 0, 0, O_CERRADA,  "fin_cerrada");
        add(0, 0, 0, 0, 1, 0, 0, O_CERRADA,  "cerrada_estable");
        add(0, 1, 0, 0, 1, 0, 0, O_ABRIENDO, "abrir_desde_cerrada");
        add(0, 0, 0, 0, 0, 0, 0, O_ABRIENDO, "abriendo_b");
        add(0, 0, 0, 1, 0, 0, 0, O_ABIERTA,  "abierta_b");
        add(0, 0, 0, 1, 0, 1, 0, O_CERRANDO, "cerrando_b");
        add(0, 1, 0, 0, 0, 0, 0, O_ABRIENDO, "reapertura_abrir");
        add(0, 0, 0, 1, 0, 0, 0, O_ABIERTA,  "abierta_c");
        add(0, 0, 0, 1, 1, 0, 0, O_FALLA,    "conflicto_abierta");
        add(0, 0, 0, 0, 0, 0, 0, O_FALLA,    "falla_absorbe");
        add(0, 1, 0, 0, 1, 0, 0, O_FALLA,    "falla_ignora_abrir");
        add(1, 0, 0, 0, 0, 0, 0, O_CERRADA,  "reset_sale_falla");
        add(0, 0, 0, 1, 1, 0, 0, O_FALLA,    "conflicto_cerrada");
        add(1, 0, 0, 0, 0, 0, 0, O_CERRADA,  "reset_final_tabla");

        for (int unsigned i = 0; i < tabla.size(); i++) begin
            paso(tabla[i].r, tabla[i].a, tabla[i].o, tabla[i].fa,
                 tabla[i].fc, tabla[i].to, tabla[i].ce,
                 tabla[i].exp, tabla[i].nombre);
        end

        // Obstacle hold for 20 cycles with timeout asserted
        paso(0, 1, 0, 0, 0, 0, 0, O_ABRIENDO, "hold_abriendo");
        paso(0, 0, 0, 1, 0, 0, 0, O_ABIERTA,  "hold_abierta");
        for (int i = 0; i < 20; i++) paso(0, 0, 1, 1, 0, 1, 0, O_ABIERTA, "hold_obst");
        paso(0, 0, 0, 1, 0, 1, 0, O_CERRANDO, "hold_libera");
        paso(0, 0, 0, 0, 1, 0, 0, O_CERRADA,  "hold_cerrada");

        // Watchdog in ABRIENDO: fault on the 9th edge after entry
        paso(0, 1, 0, 0, 0, 0, 0, O_ABRIENDO, "wd_entra");
        for (int i = 1; i <= 8; i++) paso(0, 0, 0, 0, 0, 0, 0, O_ABRIENDO, "wd_cuenta");
        paso(0, 0, 0, 0, 0, 0, 0, O_FALLA,    "wd_expira");
        for (int i = 0; i < 3; i++) paso(0, 1, 0, 1, 0, 1, 0, O_FALLA, "wd_absorbe");
        paso(1, 0, 0, 0, 0, 0, 0, O_CERRADA,  "wd_reset");

        // Limit switch on the expiry edge beats the watchdog
        paso(0, 1, 0, 0, 0, 0, 0, O_ABRIENDO, "lim_entra");
        for (int i = 1; i <= 8; i++) paso(0, 0, 0, 0, 0, 0, 0, O_ABRIENDO, "lim_cuenta");
        paso(0, 0, 0, 1, 0, 0, 0, O_ABIERTA,  "lim_fin_abierta");

        // Watchdog in CERRANDO, starting fresh from ABIERTA
        paso(0, 0, 0, 0, 0, 1, 0, O_CERRANDO, "wdc_entra");
        for (int i = 1; i <= 8; i++) paso(0, 0, 0, 0, 0, 0, 0, O_CERRANDO, "wdc_cuenta");
        paso(0, 0, 0, 0, 0, 0, 0, O_FALLA,    "wdc_expira");
        paso(1, 0, 0, 0, 0, 0, 0, O_CERRADA,  "wdc_reset");

        // Counter must restart on reopen after a partial close
        paso(0, 1, 0, 0, 0, 0, 0, O_ABRIENDO, "clr_abre");
        paso(0, 0, 0, 1, 0, 0, 0, O_ABIERTA,  "clr_abierta");
        paso(0, 0, 0, 0, 0, 1, 0, O_CERRANDO, "clr_cerrando");
        for (int i = 0; i < 5; i++) paso(0, 0, 0, 0, 0, 0, 0, O_CERRANDO, "clr_parcial");
        paso(0, 0, 1, 0, 0, 0, 0, O_ABRIENDO, "clr_reabre");
        for (int i = 1; i <= 8; i++) paso(0, 0, 0, 0, 0, 0, 0, O_ABRIENDO, "clr_cuenta");
        paso(0, 0, 0, 0, 0, 0, 0, O_FALLA,    "clr_expira");

        // Reset in mid-movement
        paso(1, 0, 0, 0, 0, 0, 0, O_CERRADA,  "mid_reset0");
        paso(0, 1, 0, 0, 0, 0, 0, O_ABRIENDO, "mid_abre");
        paso(1, 1, 0, 0, 0, 0, 0, O_CERRADA,  "mid_reset");

        // Close button
        paso(0, 1, 0, 0, 0, 0, 0, O_ABRIENDO, "btn_abre");
        paso(0, 0, 0, 1, 0, 0, 0, O_ABIERTA,  "btn_abierta");
        paso(0, 0, 0, 1, 0, 0, 0, O_ABIERTA,  "btn_espera");
`ifdef BOTON_CERRAR_EN
        paso(0, 0, 0, 1, 0, 0, 1, O_CERRANDO, "btn_cierra");
`else
        paso(0, 0, 0, 1, 0, 0, 1, O_ABIERTA,  "btn_ignorado");
        paso(0, 0, 0, 1, 0, 1, 0, O_CERRANDO, "btn_timeout");
`endif
        paso(0, 0, 0, 0, 1, 0, 0, O_CERRADA,  "btn_cerrada");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_puertas.md
Name: control_puertas

Overview:
- Door-controller FSM for the elevator car.
- Produces the 2-bit door state `estado` that the downstream door-open timeout timer consumes.
- Consumes that timer's `timeout` pulse/level to start closing.
- Drives the open/close door motor commands from the arrival request, the limit switches and the obstacle sensor.
- Flags `puerta_cerrada` so the cabin motion logic may move only with the door shut.

Parameters:
- MOV_MAX, 64: max cycles allowed in ABRIENDO or CERRANDO before declaring a motor/sensor fault.
- CNT_W, 7: width of the movement watchdog counter; must satisfy 2**CNT_W > MOV_MAX.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- abrir  in  1  open request (car stopped at floor or hall/cabin open button), level.
- obstaculo  in  1  light-curtain obstacle sensor, 1 = blocked.
- fin_abierta  in  1  limit switch, 1 = door fully open.
- fin_cerrada  in  1  limit switch, 1 = door fully closed.
- timeout  in  1  from the door-open timer; 1 = door open too long.
- cerrar  in  1  cabin close-door button (used only with BOTON_CERRAR_EN).
- estado  out  2  door state: 00 CERRADA, 01 ABIERTA, 10 CERRANDO, 11 ABRIENDO/FALLA.
- motor_abrir  out  1  open-motor drive.
- motor_cerrar  out  1  close-motor drive.
- puerta_cerrada  out  1  1 only in CERRADA.
- falla  out  1  latched fault indicator.

Behaviour:
- Single clock; synchronous active-high reset.
- All outputs are registered Moore outputs, valid the cycle after each state change.
- Reset values:
  - state = CERRADA, estado = 00, puerta_cerrada = 1.
  - motor_abrir = motor_cerrar = 0, falla = 0, watchdog = 0.
  - rst asserted mid-movement forces CERRADA and motors off the next edge.
- Internal states: CERRADA, ABRIENDO, ABIERTA, CERRANDO, FALLA.
  - FALLA presents estado = 11, both motors 0, falla = 1, puerta_cerrada = 0.
- CERRADA:
  - abrir = 1 -> ABRIENDO; otherwise stay.
- ABRIENDO:
  - Outputs: motor_abrir = 1.
  - fin_abierta = 1 -> ABIERTA.
  - Else watchdog == MOV_MAX -> FALLA.
- ABIERTA:
  - Outputs: motors 0, estado = 01 (the timer counts while 01).
  - timeout = 1 and obstaculo = 0 -> CERRANDO.
  - obstaculo = 1 holds ABIERTA regardless of timeout.
  - abrir is ignored here; the timer is not re-armed.
- CERRANDO:
  - Outputs: motor_cerrar = 1; the timeout input is ignored.
  - Transition priority, highest first:
    1. obstaculo | abrir -> ABRIENDO (reopen).
    2. fin_cerrada -> CERRADA.
    3. watchdog == MOV_MAX -> FALLA.
  - Reopen takes priority when fin_cerrada and obstaculo arrive in the same cycle.
- FALLA:
  - Absorbing; only rst exits.
- Sensor consistency:
  - fin_abierta & fin_cerrada both 1 in any non-FALLA state -> FALLA next edge.
  - This check has highest priority after rst.
- Watchdog counter:
  - Clears on every state change.
  - Increments each cycle in ABRIENDO/CERRANDO; held at 0 elsewhere.
  - Saturates at MOV_MAX; no wrap.
  - FALLA is entered on the edge where count == MOV_MAX and the limit switch is still 0, i.e. MOV_MAX+1 cycles after entry.
- Interaction with the timer:
  - Any exit from ABIERTA clears the timer within one cycle.
  - Re-entry to ABIERTA starts a fresh timeout window.

Optional Feature:
- Macro: BOTON_CERRAR_EN.
- Defined: in ABIERTA, cerrar = 1 with obstaculo = 0 -> CERRANDO, same as timeout (early close).
- Undefined: cerrar is ignored; the port remains for a uniform interface; ABIERTA exits only on timeout.

Decomposition:
- Shared package (ascensor_pkg):
  - estado encodings EST_CERRADA = 2'b00, EST_ABIERTA = 2'b01, EST_CERRANDO = 2'b10, EST_ABRIENDO = 2'b11.
  - Internal state enum typedef.
  - Shared with the timeout timer and the cabin controller.
- One natural sub-module: vigia_mov.
  - Saturating watchdog counter.
  - Inputs: clk, rst, clr, en.
  - Output: expira when count == MOV_MAX.

Test Plan:
1. Nominal cycle (MOV_MAX = 8):
   - Stimulus: rst for 2 cycles; abrir = 1 one cycle; fin_abierta = 1 after 3 cycles; timeout = 1 after 10 cycles; fin_cerrada = 1 after 3 cycles.
   - Required: estado sequence 00 -> 11 -> 01 -> 10 -> 00. motor_abrir high exactly in ABRIENDO, motor_cerrar exactly in CERRANDO. puerta_cerrada = 1 only at the ends.
2. Obstacle reopen:
   - Stimulus: in CERRANDO, obstaculo = 1 in the same cycle as fin_cerrada = 1.
   - Required: next estado = 11, motor_abrir = 1, motor_cerrar = 0.
3. Obstacle hold:
   - Stimulus: in ABIERTA, timeout = 1 with obstaculo = 1 for 20 cycles, then obstaculo = 0.
   - Required: estado stays 01 throughout, then 10 the cycle after release.
4. Watchdog fault:
   - Stimulus: abrir with fin_abierta held 0.
   - Required: FALLA on the 9th edge after entering ABRIENDO (estado = 11, falla = 1, motors 0). Stays until rst, then estado = 00, falla = 0.
5. Sensor conflict:
   - Stimulus: in CERRADA, fin_abierta = fin_cerrada = 1.
   - Required: falla = 1 next cycle, puerta_cerrada = 0.
6. BOTON_CERRAR_EN:
   - Stimulus: in ABIERTA, cerrar = 1 at cycle 2.
   - Required: defined -> estado = 10 the next cycle. Undefined -> stays 01 until timeout.
